// File: rtl/sobol_pkg.sv
// Shared constants and helpers for the multi-lane Sobol generator.
// Direction numbers come from dir_num(): dimension 0 is van der Corput,
// the rest follow the Sobol recurrence over a small primitive-polynomial set.
package sobol_pkg;

  localparam int SOBOL_W = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Polynomial degree s and inner coefficients a (a_1 is the MSB of a)
  localparam int N_POLY = 8;
  localparam int POLY_S [N_POLY] = '{1, 2, 3, 3, 4, 4, 5, 5};
  localparam int POLY_A [N_POLY] = '{0, 1, 1, 2, 1, 4, 2, 4};

  function automatic logic [SOBOL_W-1:0] gray(input logic [SOBOL_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Index of the lowest set bit; 0 for a zero argument
  function automatic int ctz(input logic [SOBOL_W-1:0] x);
    int r;
    r = 0;
    for (int i = SOBOL_W - 1; i >= 0; i--)
      if (x[i]) r = i;
    return r;
  endfunction

  // Odd initial m_k below 2^k, derived from the dimension number
  function automatic int m_init(input int d, input int k);
    return ((d * 5 + k * 3) % (1 << k)) | 1;
  endfunction

  // v_d[b] as a SOBOL_W-bit binary fraction
  function automatic logic [SOBOL_W-1:0] dir_num(input int d, input int b);
    logic [SOBOL_W-1:0][SOBOL_W-1:0] v;
    int s;
    int a;
    v = '0;
    if (d == 0) return SOBOL_W'(1) << (SOBOL_W - 1 - b);
    s = POLY_S[(d - 1) % N_POLY];
    a = POLY_A[(d - 1) % N_POLY];
    for (int k = 0; k < SOBOL_W; k++) begin
      if (k < s) begin
        v[k] = SOBOL_W'(m_init(d, k + 1)) << (SOBOL_W - 1 - k);
      end else begin
        v[k] = v[k-s] ^ (v[k-s] >> s);
        for (int j = 1; j < s; j++)
          if (((a >> (s - 1 - j)) & 1) != 0) v[k] = v[k] ^ v[k-j];
      end
    end
    return v[b];
  endfunction

endpackage

// File: rtl/sobol_dir_rom.sv
// Direction-number ROM: LANES x SEEK_BITS combinational read ports.
// Contents are elaboration-time constants from sobol_pkg::dir_num();
// lanes whose dimension is out of range read 0 and use address 0.
module sobol_dir_rom
  import sobol_pkg::*;
#(
  parameter int WIDTH     = SOBOL_W,
  parameter int M         = 50,
  parameter int LANES     = 4,
  parameter int SEEK_BITS = 8,
  parameter int DBW       = $clog2(M)
) (
  input  logic [DBW-1:0]                     dim_base,
  input  logic [SEEK_BITS*$clog2(WIDTH)-1:0] bit_addr,
  output logic [LANES*SEEK_BITS*WIDTH-1:0]   rd
);

  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(M * WIDTH);

  logic [WIDTH-1:0] rom [M*WIDTH];

  for (genvar d = 0; d < M; d++) begin : g_dim
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      localparam logic [WIDTH-1:0] VAL = WIDTH'(dir_num(d, b) >> (SOBOL_W - WIDTH));
      assign rom[d*WIDTH+b] = VAL;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DBW:0] dim;
    logic         in_range;
    assign dim      = {1'b0, dim_base} + (DBW+1)'(l);
    assign in_range = (dim < (DBW+1)'(M));
    for (genvar j = 0; j < SEEK_BITS; j++) begin : g_port
      logic [AW-1:0] idx;
      assign idx = in_range ? (AW'(dim) * AW'(WIDTH) + AW'(bit_addr[j*BW +: BW])) : '0;
      assign rd[(l*SEEK_BITS+j)*WIDTH +: WIDTH] = in_range ? rom[idx] : '0;
    end
  end

endmodule

// File: rtl/sobol_vec_gen.sv
// Multi-lane streaming Sobol point generator.
// Seeks to n0 by folding SEEK_BITS Gray bits per cycle, then streams
// `count` points (LANES adjacent dimensions per beat) by Gray-code recurrence.
// Optional SOBOL_SCRAMBLE_EN adds shift_in: a per-lane random digital shift
// latched with the command.
//
// state     | meaning
// ST_IDLE   | waiting for a command, ready_out high unless flushing
// ST_SEEK   | folding direction numbers of gray(n0) into the lanes
// ST_STREAM | presenting beat n; advances on valid_out && ready_in
module sobol_vec_gen
  import sobol_pkg::*;
#(
  parameter int WIDTH     = SOBOL_W,
  parameter int M         = 50,
  parameter int LANES     = 4,
  parameter int SEEK_BITS = 8,
  parameter int DBW       = $clog2(M)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [WIDTH-1:0]       start_idx,
  input  logic [WIDTH-1:0]       count,
  input  logic [DBW-1:0]         dim_base,
`ifdef SOBOL_SCRAMBLE_EN
  input  logic [LANES*WIDTH-1:0] shift_in,
`endif
  input  logic                   flush,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] sobol_out,
  output logic [WIDTH-1:0]       idx_out,
  output logic                   last_out,
  output logic                   busy,
  output logic                   ovf
);

  localparam int NCH = WIDTH / SEEK_BITS;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW  = $clog2(WIDTH);
  localparam int LW  = LANES * WIDTH;

  logic [1:0]                       state_q;
  logic                             armed_q;
  logic [CW-1:0]                    chunk_q;
  logic [WIDTH-1:0]                 gray_q;
  logic [WIDTH-1:0]                 n_q;
  logic [WIDTH-1:0]                 rem_q;
  logic [DBW-1:0]                   dim_q;
  logic [LW-1:0]                    x_q;
  logic [LW-1:0]                    x_nxt;
  logic                             ovf_q;
  logic [SEEK_BITS*BW-1:0]          bit_addr;
  logic [LANES*SEEK_BITS*WIDTH-1:0] rd;
  logic                             accept;
  logic                             beat_done;
  logic                             at_max;
  logic [WIDTH-1:0]                 n_inc;
  logic [BW-1:0]                    step_bit;

  assign at_max    = (n_q == '1);
  assign valid_out = (state_q == ST_STREAM);
  assign last_out  = valid_out && ((rem_q == WIDTH'(1)) || at_max);
  assign ready_out = armed_q && (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = valid_in && ready_out;
  assign beat_done = valid_out && ready_in;
  assign n_inc     = n_q + WIDTH'(1);
  assign step_bit  = BW'(ctz(SOBOL_W'(n_inc)));
  assign idx_out   = n_q;
  assign ovf       = ovf_q;

  sobol_dir_rom #(
    .WIDTH(WIDTH), .M(M), .LANES(LANES), .SEEK_BITS(SEEK_BITS), .DBW(DBW)
  ) u_rom (
    .dim_base(dim_q),
    .bit_addr(bit_addr),
    .rd      (rd)
  );

  // ROM addresses: the current Gray chunk while seeking, ctz(n+1) on port 0 while streaming
  always_comb begin
    bit_addr = '0;
    for (int j = 0; j < SEEK_BITS; j++)
      bit_addr[j*BW +: BW] = BW'(chunk_q) * BW'(SEEK_BITS) + BW'(j);
    if (state_q == ST_STREAM) bit_addr[BW-1:0] = step_bit;
  end

  // Next lane accumulators: fold a seek chunk, or one Gray-code step
  always_comb begin
    x_nxt = x_q;
    for (int l = 0; l < LANES; l++) begin
      if (state_q == ST_SEEK) begin
        for (int j = 0; j < SEEK_BITS; j++)
          if (gray_q[j]) x_nxt[l*WIDTH +: WIDTH] = x_nxt[l*WIDTH +: WIDTH] ^ rd[(l*SEEK_BITS+j)*WIDTH +: WIDTH];
      end else begin
        x_nxt[l*WIDTH +: WIDTH] = x_q[l*WIDTH +: WIDTH] ^ rd[(l*SEEK_BITS)*WIDTH +: WIDTH];
      end
    end
  end

  // FSM, counters and lane registers; flush overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      chunk_q <= '0;
      gray_q  <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      dim_q   <= '0;
      x_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (flush) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              gray_q  <= WIDTH'(gray(SOBOL_W'(start_idx)));
              x_q     <= '0;
              n_q     <= start_idx;
              rem_q   <= count;
              dim_q   <= dim_base;
              chunk_q <= '0;
              ovf_q   <= 1'b0;
              if (count != '0) state_q <= ST_SEEK;
            end
          end
          ST_SEEK: begin
            x_q     <= x_nxt;
            gray_q  <= gray_q >> SEEK_BITS;
            chunk_q <= chunk_q + CW'(1);
            if (chunk_q == CW'(NCH - 1)) state_q <= ST_STREAM;
          end
          ST_STREAM: begin
            if (at_max && (rem_q > WIDTH'(1))) ovf_q <= 1'b1;
            if (beat_done) begin
              if (last_out) begin
                state_q <= ST_IDLE;
              end else begin
                x_q   <= x_nxt;
                n_q   <= n_inc;
                rem_q <= rem_q - WIDTH'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SOBOL_SCRAMBLE_EN
  logic [LW-1:0] shift_q;

  // Digital shift is captured with the command and held for its duration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '0;
    else if (accept) shift_q <= shift_in;
  end

  assign sobol_out = x_q ^ shift_q;
`else
  assign sobol_out = x_q;
`endif

endmodule
